par_serial: RTL and testbench

Parallel-to-serial stage directly downstream of the 2:1 byte mux. It samples the mux's 8-bit output and valid flag once per byte period and shifts the byte out MSB-first on a 1-bit line, one bit per clock. After reset it first emits a fixed number of COM idle symbols (0xBC) for link alignment. After that, whenever the mux has no valid byte, it substitutes COM.

---
 rtl/par_serial_pkg.sv | 13 +
 rtl/piso_shreg.sv | 33 +++
 rtl/par_serial.sv | 81 ++++++++
 tb/tb_par_serial.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/par_serial_pkg.sv
// Shared constants and state encoding for the par_serial
// parallel-to-serial stage.
package par_serial_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam logic [BYTE_W-1:0] COM_SYMBOL = 8'hBC;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/piso_shreg.sv
// Byte-wide load/shift register, MSB-first serial output,
// asynchronous active-low clear.
module piso_shreg
   import par_serial_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [BYTE_W-1:0] din,
   output logic              sout
);

   logic [BYTE_W-1:0] shreg_q;
   logic [BYTE_W-1:0] shreg_d;

   always_comb begin
      shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
      if (load) begin
         shreg_d = din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign sout = shreg_q[BYTE_W-1];

endmodule

// File: rtl/par_serial.sv
// Parallel-to-serial stage: emits IDLE_SYMS COM symbols after
// reset, then one sampled byte (or COM when idle) per 8 clocks.
module par_serial
   import par_serial_pkg::*;
#(
   parameter int unsigned IDLE_SYMS = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   output logic              data_out,
   output logic              take,
   output logic              active
);

   localparam logic [3:0] LAST_COM = 4'(IDLE_SYMS - 1);

   logic [2:0]        bit_cnt_q;
   logic [3:0]        com_cnt_q;
   state_e            state_q;
   logic              active_q;
   logic              load;
   logic [BYTE_W-1:0] sel_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_q + 3'd1;
      end
   end

   assign load = (bit_cnt_q == 3'd7);

   always_comb begin
      sel_byte = COM_SYMBOL;
      if (state_q == RUN && valid_in) begin
         sel_byte = data_in;
      end
   end

   // Alignment FSM: count COM loads in INIT, then stay in RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= INIT;
         com_cnt_q <= '0;
         active_q  <= 1'b0;
      end else begin
         unique case (state_q)
            INIT: begin
               if (load) begin
                  com_cnt_q <= com_cnt_q + 4'd1;
                  if (com_cnt_q == LAST_COM) begin
                     state_q  <= RUN;
                     active_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               active_q <= 1'b1;
            end
            default: begin
               state_q <= INIT;
            end
         endcase
      end
   end

   piso_shreg u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .din   (sel_byte),
      .sout  (data_out)
   );

   assign take   = load;
   assign active = active_q;

endmodule

// File: tb/tb_par_serial.sv
// Directed self-checking bench for par_serial (IDLE_SYMS=4).
module tb_par_serial;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       data_out;
   logic       take;
   logic       active;

   int n_tests;
   int n_fail;
   int ecnt;

   logic [7:0] com_v;

   par_serial #(.IDLE_SYMS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .valid_in (valid_in),
      .data_out (data_out),
      .take     (take),
      .active   (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      data_in  = 8'h00;
      valid_in = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({data_out, take, active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_async: got %b want 000",
                  {data_out, take, active});
      end
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({data_out, take, active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_held: got %b want 000",
                  {data_out, take, active});
      end
      @(negedge clk);
      reset = 1'b1;
      ecnt  = 0;
   endtask

   task automatic test_align(input string tag);
      logic ed, et, ea;
      valid_in = 1'b0;
      for (int e = 1; e <= 39; e++) begin
         tick();
         ed = (e < 8) ? 1'b0 : com_v[7 - (e % 8)];
         et = ((e % 8) == 7);
         ea = (e >= 32);
         n_tests++;
         if (data_out !== ed) begin
            n_fail++;
            $display("FAIL %s data_out edge %0d: got %b want %b",
                     tag, e, data_out, ed);
         end
         n_tests++;
         if (take !== et) begin
            n_fail++;
            $display("FAIL %s take edge %0d: got %b want %b",
                     tag, e, take, et);
         end
         n_tests++;
         if (active !== ea) begin
            n_fail++;
            $display("FAIL %s active edge %0d: got %b want %b",
                     tag, e, active, ea);
         end
      end
   endtask

   task automatic test_data();
      logic [7:0] b;
      b        = 8'hA5;
      data_in  = b;
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (data_out !== b[7 - i]) begin
            n_fail++;
            $display("FAIL data_A5 edge %0d: got %b want %b",
                     ecnt, data_out, b[7 - i]);
         end
      end
   endtask

   task automatic test_idle_com();
      data_in  = 8'hFF;
      valid_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (data_out !== com_v[7 - i]) begin
            n_fail++;
            $display("FAIL idle_com edge %0d: got %b want %b",
                     ecnt, data_out, com_v[7 - i]);
         end
      end
   endtask

   task automatic test_mid_change();
      logic [7:0] b;
      b        = 8'h3C;
      data_in  = b;
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (data_out !== b[7 - i]) begin
            n_fail++;
            $display("FAIL mid_change edge %0d: got %b want %b",
                     ecnt, data_out, b[7 - i]);
         end
         if (i == 2) data_in = 8'hC3;
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] s;
      s        = 24'h01_80_00;
      data_in  = 8'h01;
      valid_in = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         n_tests++;
         if (data_out !== s[23 - i]) begin
            n_fail++;
            $display("FAIL back_to_back edge %0d: got %b want %b",
                     ecnt, data_out, s[23 - i]);
         end
         if (i == 7)  data_in = 8'h80;
         if (i == 15) data_in = 8'h00;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      data_in  = 8'hFF;
      valid_in = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({data_out, take, active} !== 3'b101) begin
         n_fail++;
         $display("FAIL pre_reset edge %0d: got %b want 101",
                  ecnt, {data_out, take, active});
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if ({data_out, take, active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b want 000",
                  {data_out, take, active});
      end
      @(posedge clk);
      #1;
      n_tests++;
      if ({data_out, take, active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_held: got %b want 000",
                  {data_out, take, active});
      end
      @(negedge clk);
      reset = 1'b1;
      ecnt  = 0;
      test_align("replay");
      b        = 8'h5A;
      data_in  = b;
      valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (data_out !== b[7 - i]) begin
            n_fail++;
            $display("FAIL replay_data edge %0d: got %b want %b",
                     ecnt, data_out, b[7 - i]);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      ecnt    = 0;
      com_v   = 8'hBC;
      test_reset();
      test_align("align");
      test_data();
      test_idle_com();
      test_mid_change();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
